// File: rtl/fifo_ring.sv
// Circular-buffer synchronous FIFO with first-word-fall-through output,
// occupancy count, almost-full/almost-empty thresholds and error pulses.
module fifo_ring #(
    parameter int WD     = 8,
    parameter int AW     = 4,
    parameter int AF_LVL = 2**AW - 2,
    parameter int AE_LVL = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [WD-1:0] d_in,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    output logic [WD-1:0] d_out,
    output logic          empty,
    output logic          full,
    output logic          almost_empty,
    output logic          almost_full,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          underflow
);

    localparam int          DEPTH     = 2**AW;
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_CNT    = (AW+1)'(AF_LVL);
    localparam logic [AW:0] AE_CNT    = (AW+1)'(AE_LVL);

    logic [WD-1:0] mem [0:DEPTH-1];

    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [AW:0]   count_reg, count_next;
    logic          overflow_reg, overflow_next;
    logic          underflow_reg, underflow_next;
    logic          push_ok, pop_ok, wr_en;

    // A pop frees a slot in the same cycle, so a full FIFO can still accept a push alongside it.
    always_comb begin
        pop_ok         = pop && (count_reg != '0);
        push_ok        = push && ((count_reg != DEPTH_CNT) || pop_ok);
        wr_ptr_next    = wr_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        count_next     = count_reg;
        overflow_next  = 1'b0;
        underflow_next = 1'b0;
        wr_en          = 1'b0;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            wr_en          = push_ok && !reset;
            overflow_next  = push && !push_ok;
            underflow_next = pop && !pop_ok;
            if (push_ok) begin
                wr_ptr_next = wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_next = rd_ptr_reg + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count_next = count_reg + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count_next = count_reg - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    // Storage is never cleared; stale words are hidden by count and the d_out mask.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= d_in;
        end
    end

    assign d_out        = (count_reg != '0) ? mem[rd_ptr_reg] : '0;
    assign count        = count_reg;
    assign empty        = (count_reg == '0);
    assign full         = (count_reg == DEPTH_CNT);
    assign almost_empty = (count_reg <= AE_CNT);
    assign almost_full  = (count_reg >= AF_CNT);
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

endmodule
